// File: rtl/banco_registradores.sv
// MIPS register file: 32 x LARGURA registers, one write port, two registered read ports
// with same-edge write-to-read bypass and a 16-bit committed-write counter for debug.
module banco_registradores #(
    parameter int LARGURA = 32,
    parameter int NUM_REG = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               EscreveRegControl,
    input  logic [4:0]         EscreveReg,
    input  logic [LARGURA-1:0] DadoEscrita,
    input  logic [4:0]         LeReg1,
    input  logic [4:0]         LeReg2,
    output logic [LARGURA-1:0] Dado1,
    output logic [LARGURA-1:0] Dado2,
    output logic [15:0]        ContEscritas
);

    logic [LARGURA-1:0] regs [NUM_REG];
    logic               write_ok;
    logic [LARGURA-1:0] next_dado1;
    logic [LARGURA-1:0] next_dado2;

    // r0 is hardwired to zero, so writes to it never commit or count.
    assign write_ok = EscreveRegControl && (EscreveReg != 5'd0);

    always_comb begin
        next_dado1 = regs[LeReg1];
        next_dado2 = regs[LeReg2];
        if (LeReg1 == 5'd0) begin
            next_dado1 = '0;
        end else if (EscreveRegControl && (EscreveReg == LeReg1)) begin
            next_dado1 = DadoEscrita;
        end
        if (LeReg2 == 5'd0) begin
            next_dado2 = '0;
        end else if (EscreveRegControl && (EscreveReg == LeReg2)) begin
            next_dado2 = DadoEscrita;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REG; i++) begin
                regs[i] <= '0;
            end
            ContEscritas <= 16'd0;
        end else if (write_ok) begin
            regs[EscreveReg] <= DadoEscrita;
            ContEscritas     <= ContEscritas + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            Dado1 <= '0;
            Dado2 <= '0;
        end else begin
            Dado1 <= next_dado1;
            Dado2 <= next_dado2;
        end
    end

endmodule

// File: tb/tb_banco_registradores.sv
// Self-checking bench for banco_registradores: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_banco_registradores;

    logic        clock;
    logic        reset;
    logic        EscreveRegControl;
    logic [4:0]  EscreveReg;
    logic [31:0] DadoEscrita;
    logic [4:0]  LeReg1;
    logic [4:0]  LeReg2;
    logic [31:0] Dado1;
    logic [31:0] Dado2;
    logic [15:0] ContEscritas;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl [32];
    logic [15:0] mdl_cnt;
    logic [31:0] exp1;
    logic [31:0] exp2;

    banco_registradores #(.LARGURA(32), .NUM_REG(32)) dut (
        .clock            (clock),
        .reset            (reset),
        .EscreveRegControl(EscreveRegControl),
        .EscreveReg       (EscreveReg),
        .DadoEscrita      (DadoEscrita),
        .LeReg1           (LeReg1),
        .LeReg2           (LeReg2),
        .Dado1            (Dado1),
        .Dado2            (Dado2),
        .ContEscritas     (ContEscritas)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [4:0] r, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
        if (r == 5'd0) return 32'h0;
        if (we && wa == r) return wd;
        return mdl[r];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        mdl_cnt = 16'h0;
    endtask

    // One clock: drive at negedge, predict, then check just after the rising edge.
    task automatic step(input string tag, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clock);
        EscreveRegControl = we;
        EscreveReg        = wa;
        DadoEscrita       = wd;
        LeReg1            = r1;
        LeReg2            = r2;
        exp1 = ref_read(r1, we, wa, wd);
        exp2 = ref_read(r2, we, wa, wd);
        if (we && wa != 5'd0) begin
            mdl[wa] = wd;
            mdl_cnt = mdl_cnt + 16'd1;
        end
        @(posedge clock);
        #1;
        chk({tag, "_d1"}, Dado1, exp1);
        chk({tag, "_d2"}, Dado2, exp2);
        chk({tag, "_cnt"}, {16'h0, ContEscritas}, {16'h0, mdl_cnt});
    endtask

    // Asserts reset between edges with a pending write, checks the immediate clear.
    task automatic async_reset(input string tag);
        @(negedge clock);
        EscreveRegControl = 1'b1;
        EscreveReg        = 5'd7;
        DadoEscrita       = 32'hCAFE_F00D;
        #2;
        reset = 1'b1;
        #1;
        chk({tag, "_d1"}, Dado1, 32'h0);
        chk({tag, "_d2"}, Dado2, 32'h0);
        chk({tag, "_cnt"}, {16'h0, ContEscritas}, 32'h0);
        clear_model();
        @(posedge clock);
        @(negedge clock);
        reset             = 1'b0;
        EscreveRegControl = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        EscreveRegControl = 1'b0;
        EscreveReg        = 5'd0;
        DadoEscrita       = 32'h0;
        LeReg1            = 5'd0;
        LeReg2            = 5'd0;
        clear_model();
        #1;
        chk("por_d1", Dado1, 32'h0);
        chk("por_d2", Dado2, 32'h0);
        chk("por_cnt", {16'h0, ContEscritas}, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        step("rst_wr", 1'b1, 5'd5, 32'h1234, 5'd0, 5'd0);
        step("rst_rd", 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        chk("rst_rd_val", Dado1, 32'h1234);
        async_reset("arst");
        step("rst_after", 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        chk("rst_after_r5", Dado1, 32'h0);

        step("basic_wr", 1'b1, 5'd8, 32'hDEAD_BEEF, 5'd0, 5'd0);
        step("basic_rd", 1'b0, 5'd0, 32'h0, 5'd8, 5'd0);
        chk("basic_val", Dado1, 32'hDEAD_BEEF);
        chk("basic_cnt1", {16'h0, ContEscritas}, 32'd1);

        step("r0_wr", 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        step("r0_rd", 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        chk("r0_cnt", {16'h0, ContEscritas}, 32'd1);

        step("byp_init", 1'b1, 5'd9, 32'h11, 5'd0, 5'd0);
        step("byp_on", 1'b1, 5'd9, 32'h22, 5'd9, 5'd9);
        chk("byp_on_d1", Dado1, 32'h22);
        chk("byp_on_d2", Dado2, 32'h22);
        step("byp_reinit", 1'b1, 5'd9, 32'h11, 5'd0, 5'd0);
        step("byp_off", 1'b0, 5'd9, 32'h22, 5'd9, 5'd9);
        chk("byp_off_d1", Dado1, 32'h11);
        chk("byp_off_d2", Dado2, 32'h11);

        step("ind_w3", 1'b1, 5'd3, 32'hA, 5'd0, 5'd0);
        step("ind_w4", 1'b1, 5'd4, 32'hB, 5'd0, 5'd0);
        step("ind_rd", 1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
        chk("ind_d1", Dado1, 32'hA);
        chk("ind_d2", Dado2, 32'hB);
        step("ind_swap", 1'b0, 5'd0, 32'h0, 5'd4, 5'd3);
        chk("swap_d1", Dado1, 32'hB);
        chk("swap_d2", Dado2, 32'hA);

        for (int i = 0; i < 3000; i++) begin
            step("rand", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        async_reset("wrap_rst");
        for (int i = 0; i < 65536; i++) begin
            step("wrap", 1'b1, 5'($urandom_range(1, 31)), $urandom,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
        chk("wrap_cnt_zero", {16'h0, ContEscritas}, 32'h0);
        for (int r = 1; r < 32; r++) begin
            step("wrap_rb", 1'b0, 5'd0, 32'h0, 5'(r), 5'(32 - r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
